// File: rtl/alu_pkg.sv
// Shared types for the serial ALU: operation codes and controller states.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_NOR = 2'b00,
        OP_XOR = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_slice.sv
// One-bit ALU slice; SUB is an add of a, ~b and the incoming carry.
module alu_slice
    import alu_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  op_t  op,
    output logic s,
    output logic cout
);

    logic b_eff;

    always_comb begin
        s     = 1'b0;
        cout  = 1'b0;
        b_eff = (op == OP_SUB) ? ~b : b;
        case (op)
            OP_NOR: s = ~(a | b);
            OP_XOR: s = a ^ b;
            default: begin
                s    = a ^ b_eff ^ cin;
                cout = (a & b_eff) | (a & cin) | (b_eff & cin);
            end
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Multi-cycle ALU iterating BITS_PER_CYCLE chained slices LSB first.
// Optional zero/ovf outputs are built when ALU_SERIAL_FLAGS_EN is defined.
//   state | meaning
//   IDLE  | ready, waiting for start
//   RUN   | one chunk per cycle into the accumulator
//   DONE  | one-cycle done strobe, result/cout valid
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef ALU_SERIAL_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  result_q, result_d;
    op_t               op_q, op_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;

    logic [BITS_PER_CYCLE:0]   chain;
    logic [BITS_PER_CYCLE-1:0] chunk_s;
    logic [WIDTH-1:0]          acc_next;
    logic                      is_arith;

`ifdef ALU_SERIAL_FLAGS_EN
    logic zero_q, zero_d, ovf_q, ovf_d;
`endif

    assign chain[0] = carry_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_slice
        alu_slice u_slice (
            .a    (a_q[i]),
            .b    (b_q[i]),
            .cin  (chain[i]),
            .op   (op_q),
            .s    (chunk_s[i]),
            .cout (chain[i+1])
        );
    end

    // New chunk enters at the top; after STEPS shifts bit 0 lands in place.
    assign acc_next = (acc_q >> BITS_PER_CYCLE) | (WIDTH'(chunk_s) << (WIDTH - BITS_PER_CYCLE));
    assign is_arith = op_q[1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef ALU_SERIAL_FLAGS_EN
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op_t'(op);
                    cnt_d   = '0;
                    carry_d = (op == 2'b11);
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> BITS_PER_CYCLE;
                b_d     = b_q >> BITS_PER_CYCLE;
                acc_d   = acc_next;
                carry_d = chain[BITS_PER_CYCLE];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    result_d = acc_next;
                    cout_d   = is_arith & chain[BITS_PER_CYCLE];
`ifdef ALU_SERIAL_FLAGS_EN
                    zero_d   = (acc_next == '0);
                    ovf_d    = is_arith & (chain[BITS_PER_CYCLE] ^ chain[BITS_PER_CYCLE-1]);
`endif
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_NOR;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef ALU_SERIAL_FLAGS_EN
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
`ifdef ALU_SERIAL_FLAGS_EN
    assign zero   = zero_q;
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: a BITS_PER_CYCLE=1 and a BITS_PER_CYCLE=4 instance.
module tb_alu_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start0 = 0, start1 = 0;
    logic [1:0] op0 = 0, op1 = 0;
    logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic       ready0, done0, cout0, ready1, done1, cout1;
    logic [7:0] result0, result1;
    logic       zero0, ovf0, zero1, ovf1;

    alu_serial #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .op(op0), .a(a0), .b(b0),
        .ready(ready0), .done(done0), .result(result0), .cout(cout0)
`ifdef ALU_SERIAL_FLAGS_EN
        , .zero(zero0), .ovf(ovf0)
`endif
    );

    alu_serial #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1),
        .ready(ready1), .done(done1), .result(result1), .cout(cout1)
`ifdef ALU_SERIAL_FLAGS_EN
        , .zero(zero1), .ovf(ovf1)
`endif
    );

`ifndef ALU_SERIAL_FLAGS_EN
    assign zero0 = 1'b0;
    assign ovf0  = 1'b0;
    assign zero1 = 1'b0;
    assign ovf1  = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    logic       s_ready, s_done, s_cout, s_zero, s_ovf;
    logic [7:0] s_res;

    typedef struct {
        int         w;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       o;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic sample(input int w);
        if (w == 0) begin
            s_ready = ready0; s_done = done0; s_res = result0;
            s_cout = cout0; s_zero = zero0; s_ovf = ovf0;
        end else begin
            s_ready = ready1; s_done = done1; s_res = result1;
            s_cout = cout1; s_zero = zero1; s_ovf = ovf1;
        end
    endtask

    task automatic drive(input int w, input logic st, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        if (w == 0) begin
            start0 = st; op0 = op; a0 = a; b0 = b;
        end else begin
            start1 = st; op1 = op; a1 = a; b1 = b;
        end
    endtask

    // Reference: whole-word arithmetic on the captured operands.
    task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic c, output logic z, output logic o);
        logic [8:0] s9;
        c = 1'b0;
        o = 1'b0;
        case (op)
            2'b00: r = ~(a | b);
            2'b01: r = a ^ b;
            2'b10: begin
                s9 = {1'b0, a} + {1'b0, b};
                r  = s9[7:0];
                c  = s9[8];
                o  = (a[7] == b[7]) && (r[7] != a[7]);
            end
            default: begin
                r = a - b;
                c = (a >= b);
                o = (a[7] != b[7]) && (r[7] != a[7]);
            end
        endcase
        z = (r == 8'h00);
    endtask

    task automatic run_op(input int w, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] er, input logic ec,
                          input logic ez, input logic eo, input string nm);
        int         steps;
        int         n;
        logic [7:0] prev;
        logic       hold_bad;
        logic       busy_bad;
        steps    = (w == 0) ? 8 : 2;
        hold_bad = 1'b0;
        busy_bad = 1'b0;
        @(negedge clk);
        sample(w);
        chk({nm, "_ready_before"}, 32'(s_ready), 32'd1);
        prev = s_res;
        drive(w, 1'b1, op, a, b);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            sample(w);
            if (s_ready) busy_bad = 1'b1;
            // Competing requests and operand changes while busy must be ignored.
            drive(w, 1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 8'($urandom));
            if (s_done) break;
            if (s_res !== prev) hold_bad = 1'b1;
        end
        chk({nm, "_latency"}, 32'(n), 32'(steps + 1));
        chk({nm, "_result"}, 32'(s_res), 32'(er));
        chk({nm, "_cout"}, 32'(s_cout), 32'(ec));
`ifdef ALU_SERIAL_FLAGS_EN
        chk({nm, "_zero"}, 32'(s_zero), 32'(ez));
        chk({nm, "_ovf"}, 32'(s_ovf), 32'(eo));
`endif
        chk({nm, "_hold"}, 32'(hold_bad), 32'd0);
        chk({nm, "_busy_ready"}, 32'(busy_bad), 32'd0);
        @(negedge clk);
        sample(w);
        chk({nm, "_done_single"}, 32'(s_done), 32'd0);
        chk({nm, "_ready_after"}, 32'(s_ready), 32'd1);
        chk({nm, "_result_kept"}, 32'(s_res), 32'(er));
        drive(w, 1'b0, 2'b00, 8'h00, 8'h00);
    endtask

    initial begin
        logic [7:0] r;
        logic       c, z, o;
        logic [1:0] rop;
        logic [7:0] ra, rb;
        int         n;
        logic       strobe;

        vecs[0] = '{0, 2'b10, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{0, 2'b11, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{0, 2'b11, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{0, 2'b00, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{0, 2'b01, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1, 2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1, 2'b11, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{0, 2'b10, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            sample(w);
            chk($sformatf("rst%0d_ready", w), 32'(s_ready), 32'd1);
            chk($sformatf("rst%0d_done", w), 32'(s_done), 32'd0);
            chk($sformatf("rst%0d_result", w), 32'(s_res), 32'd0);
            chk($sformatf("rst%0d_cout", w), 32'(s_cout), 32'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].w, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].c, vecs[i].z, vecs[i].o, $sformatf("vec%0d", i));

        // Abort mid-operation: leave a nonzero result first so the clear is visible.
        run_op(0, 2'b01, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, "pre_abort");
        @(negedge clk);
        drive(0, 1'b1, 2'b10, 8'h12, 8'h34);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(0, 1'b0, 2'b00, 8'h00, 8'h00);
        end
        rst_n = 1'b0;
        #1;
        sample(0);
        chk("abort_ready", 32'(s_ready), 32'd1);
        chk("abort_done", 32'(s_done), 32'd0);
        chk("abort_result", 32'(s_res), 32'd0);
        chk("abort_cout", 32'(s_cout), 32'd0);
        strobe = 1'b0;
        for (n = 0; n < 3; n++) begin
            @(negedge clk);
            if (done0) strobe = 1'b1;
        end
        rst_n = 1'b1;
        for (n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done0) strobe = 1'b1;
        end
        chk("abort_no_done", 32'(strobe), 32'd0);
        model(2'b10, 8'h12, 8'h34, r, c, z, o);
        run_op(0, 2'b10, 8'h12, 8'h34, r, c, z, o, "post_abort");

        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom);
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            if (i % 5 == 0) rb = ra;
            model(rop, ra, rb, r, c, z, o);
            run_op(i % 2, rop, ra, rb, r, c, z, o, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
